slow_clock_monitor: RTL
=======================

// Module: slow_clock_monitor
// PURPOSE
//  Receives a slow divided clock or tick, e.g. the 1 Hz game tick, on clk_in and
//  brings it into the clock_100Mhz domain. Produces one-cycle rise/fall strobes
//  that logic uses as clock enables instead of clocking flops from clk_in.
//  Measures the clk_in period in clock_100Mhz cycles and flags loss of clock.
//  It is the consumer-side counterpart of the clock dividers.
// PARAMETERS
//  SYNC_STAGES  2          synchroniser depth on clk_in (>=2)
//  CNT_W        32         width of the cycle counter and period output
//  TIMEOUT      4_000_000  cycles with no rising edge before clock_lost (< 2^CNT_W)
// PORTS
//  clock_100Mhz  in   1      system clock
//  reset         in   1      synchronous, active-high
//  clk_in        in   1      asynchronous slow clock/tick to monitor
//  rise_strobe   out  1      one-cycle pulse per clk_in rising edge
//  fall_strobe   out  1      one-cycle pulse per clk_in falling edge
//  period        out  CNT_W  last measured rise-to-rise period, in clock_100Mhz cycles
//  period_valid  out  1      one-cycle pulse when period updates
//  locked        out  1      at least one full period measured since the last loss/reset
//  clock_lost    out  1      no rising edge seen for TIMEOUT cycles
// BEHAVIOUR
//  - Reset is synchronous, active-high, on clock clock_100Mhz. All outputs are 0 at reset.
//    The synchroniser chain, edge register and cnt clear to 0. State goes to IDLE.
//  - Synchroniser: SYNC_STAGES flops. Edge detect compares the last stage with one more flop.
//  - Strobes are registered. If clk_in is first sampled high at edge k, rise_strobe is
//    high for the cycle after edge k+SYNC_STAGES (latency SYNC_STAGES+1). fall_strobe
//    behaves the same way for falling edges.
//  - cnt (CNT_W bits) is loaded with 1 in the cycle a rise is detected. Otherwise it
//    increments, saturating at all-ones. It never wraps.
//  - States and transitions:
//    IDLE    : rise -> MEASURE (cnt=1). cnt==TIMEOUT -> LOST.
//    MEASURE : rise -> LOCKED, period<=cnt, period_valid=1. cnt==TIMEOUT -> LOST.
//    LOCKED  : rise -> period<=cnt, period_valid=1, stay. cnt==TIMEOUT -> LOST.
//    LOST    : rise -> MEASURE (period not updated; stale count).
//  - Output flags:
//    locked=1 only in LOCKED, registered and coincident with the first period_valid.
//    clock_lost=1 only in LOST. It asserts the cycle after cnt reaches TIMEOUT.
//  - Simultaneous rise and cnt==TIMEOUT: the rise wins and no LOST entry occurs.
//  - period holds its value through LOST and MEASURE. Only reset clears it.
//  - Fastest supported clk_in: a period of 2 cycles (toggling every cycle) gives period=2.
//    Pulses shorter than one clock_100Mhz cycle may be missed. This is not an error.
//  - A reset mid-measurement discards the partial count. After reset a full period is
//    needed again before locked asserts.
// TESTING (bench uses TIMEOUT=64, SYNC_STAGES=2)
//  1 Reset: hold reset 5 cycles with clk_in toggling.
//    -> all outputs 0 throughout, no strobes.
//  2 Steady input: clk_in toggles every 10 cycles.
//    -> first rise: rise_strobe only.
//    -> second rise: period=20, period_valid pulse, locked=1.
//    -> every later rise: period=20.
//  3 Latency: clk_in rises just before edge k.
//    -> rise_strobe high for exactly 1 cycle, after edge k+2.
//    -> fall_strobe timed the same way on the falling edge.
//  4 Loss and recovery: stop clk_in low after a rise.
//    -> clock_lost=1 and locked=0, 64 cycles later.
//    -> on restart, clock_lost clears at the first rise.
//    -> locked and period_valid return at the second rise.
//  5 Boundaries: the rise lands exactly when cnt==64.
//    -> no clock_lost, period=64.
//    -> with clk_in toggling every cycle, period=2 on each rise.
//  6 Mid-measure reset: assert reset between two rises, then release.
//    -> outputs 0, period=0.
//    -> first post-reset rise gives no period_valid.

Source files
------------

// File: rtl/slow_clock_monitor_if.sv
// Slow clock monitor bus: monitored clock in, strobes and period out.
// master drives clk_in, slave is the monitor.
interface slow_clock_monitor_if #(
  parameter int CNT_W = 32
);
  logic             clk_in;
  logic             rise_strobe;
  logic             fall_strobe;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             clock_lost;

  modport master (
    output clk_in,
    input  rise_strobe, fall_strobe, period,
    input  period_valid, locked, clock_lost
  );

  modport slave (
    input  clk_in,
    output rise_strobe, fall_strobe, period,
    output period_valid, locked, clock_lost
  );
endinterface

// File: rtl/slow_clock_monitor.sv
// Synchronises a slow clock/tick, emits edge strobes and
// measures its rise-to-rise period with loss detection.
module slow_clock_monitor #(
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 4_000_000
) (
  input  logic                 clock_100Mhz,
  input  logic                 reset,
  slow_clock_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_period;
  logic                   r_pv;
  state_t                 r_state;
  state_t                 w_next;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_tmo;
  logic                   w_pv;

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_fall = ~r_sync[SYNC_STAGES-1] & r_prev;
  assign w_tmo  = (r_cnt == LP_TMO);

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_sync   <= '0;
      r_prev   <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_pv     <= 1'b0;
      r_state  <= IDLE;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.clk_in};
      r_prev  <= r_sync[SYNC_STAGES-1];
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_pv    <= w_pv;
      r_state <= w_next;
      // saturate so a dead input can never alias to a short period
      if (w_rise)
        r_cnt <= CNT_W'(1);
      else if (r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_pv)
        r_period <= r_cnt;
    end
  end

  always_comb begin
    w_next = r_state;
    w_pv   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise)     w_next = MEASURE;
        else if (w_tmo) w_next = LOST;
      end
      MEASURE: begin
        if (w_rise) begin
          w_next = LOCKED;
          w_pv   = 1'b1;
        end else if (w_tmo) begin
          w_next = LOST;
        end
      end
      LOCKED: begin
        if (w_rise)     w_pv   = 1'b1;
        else if (w_tmo) w_next = LOST;
      end
      LOST: begin
        if (w_rise)     w_next = MEASURE;
      end
      default:          w_next = IDLE;
    endcase
  end

  assign bus.rise_strobe  = r_rise;
  assign bus.fall_strobe  = r_fall;
  assign bus.period       = r_period;
  assign bus.period_valid = r_pv;
  assign bus.locked       = (r_state == LOCKED);
  assign bus.clock_lost   = (r_state == LOST);

endmodule
